// File: rtl/island_pkg.sv
// rtl/island_pkg.sv - shared types and defaults for the island symbol feeder
package island_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } feeder_state_t;

  localparam sym_t SYM_IDLE_DEFAULT = 2'b00;

endpackage

// File: rtl/island_sym_fifo.sv
// rtl/island_sym_fifo.sv - DEPTH-entry symbol FIFO with registered occupancy
module island_sym_fifo
  import island_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [1:0]    push_sym,
  input  logic          pop,
  output logic [1:0]    head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  sym_t          mem_q [DEPTH];
  sym_t          mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_sym;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy untouched.
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/island_symbol_feeder.sv
// rtl/island_symbol_feeder.sv - buffers producer symbols and replays each for HOLD_CYCLES clocks
// Optional sticky overflow flag output enabled by ISLAND_FEEDER_OVF_EN.
module island_symbol_feeder
  import island_pkg::*;
#(
  parameter int   DEPTH       = 8,
  parameter int   HOLD_CYCLES = 2,
  parameter sym_t IDLE_SYM    = SYM_IDLE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [1:0]                 in_sym,
  output logic                       in_ready,
  output logic [1:0]                 data_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef ISLAND_FEEDER_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  feeder_state_t state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  sym_t          data_out_q, data_out_d;

  logic          fifo_push;
  logic          fifo_pop;
  sym_t          fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;

  // in_ready comes from the registered occupancy only, so a same-cycle pop never frees a slot early.
  assign fifo_push = in_valid && !fifo_full;

  island_sym_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_sym (in_sym),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      data_out_q <= IDLE_SYM;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = HOLD;
      HOLD: if ((hold_cnt_q == '0) && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = 1'b0;
    hold_cnt_d = hold_cnt_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          data_out_d = fifo_head;
          hold_cnt_d = HOLD_RELOAD;
        end else begin
          data_out_d = IDLE_SYM;
        end
      end
      HOLD: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else if (!fifo_empty) begin
          // Last hold cycle with more queued: chain the next symbol with no idle gap.
          fifo_pop   = 1'b1;
          data_out_d = fifo_head;
          hold_cnt_d = HOLD_RELOAD;
        end else begin
          data_out_d = IDLE_SYM;
        end
      end
      default: begin
        data_out_d = IDLE_SYM;
      end
    endcase
  end

`ifdef ISLAND_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (in_valid && fifo_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready = !fifo_full;
  assign data_out = data_out_q;
  assign busy     = (state_q == HOLD);
  assign level    = fifo_level;

endmodule
